bus_sram_slave: RTL and testbench
=================================

BUS_SRAM_SLAVE -- requirements
Module: bus_sram_slave

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_0000: bus address window base.
REQ-002 SHALL have parameter ADDR_MASK, default 32'hFFC0_0000: a bit set to 1 takes part in the window compare.
REQ-003 SHALL have parameter WAIT_CYCLES, default 2: SRAM strobe length in clk cycles; legal range 1..15.
REQ-004 SHALL have parameter MEM_AW, default 20: SRAM word-address width, driven from bus_addr[MEM_AW+1:2].
REQ-005 SHALL use one clock; reset is synchronous and active-low.
REQ-006 clk  in  1  sole clock, rising edge.
REQ-007 reset_n  in  1  synchronous active-low reset.
REQ-008 bus_addr  in  32  byte address from the bus controller.
REQ-009 bus_wdata  in  32  write data.
REQ-010 bus_rreq / bus_wreq  in  1 each  read / write request.
REQ-011 bus_ack  out  1  claims the current request.
REQ-012 bus_busy  out  1  access in progress.
REQ-013 bus_rdata  out  32  registered read data.
REQ-014 mem_addr  out  MEM_AW  SRAM word address.
REQ-015 mem_dq_o / mem_dq_oe  out  32 / 1  write data and output enable for the IO pad.
REQ-016 mem_dq_i  in  32  SRAM read data.
REQ-017 mem_ce_n, mem_oe_n, mem_we_n  out  1 each  active-low SRAM strobes.

Function
REQ-018 hit SHALL equal ((bus_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK)); bus_ack SHALL equal combinationally (bus_rreq | bus_wreq) & hit, with no latency.
REQ-019 FSM states SHALL be IDLE, RD, WR, WR_REC and DONE.
REQ-020 IDLE: on hit & bus_wreq, latch addr/wdata and go to WR; else on hit & bus_rreq, latch addr and go to RD. Write SHALL win if both requests are high.
REQ-021 RD: mem_ce_n=0, mem_oe_n=0 and bus_busy=1 for exactly WAIT_CYCLES cycles; on the final cycle, capture mem_dq_i into bus_rdata and go to DONE.
REQ-022 WR: mem_ce_n=0, mem_we_n=0 and mem_dq_oe=1 for WAIT_CYCLES cycles, then WR_REC: one cycle with mem_we_n=1, mem_ce_n=0 and data still driven, then DONE. bus_busy SHALL be 1 through WR and WR_REC.
REQ-023 DONE: bus_busy=0 and bus_rdata stable. Go to IDLE when both requests are low. If bus_rreq stays high and bus_addr differs from the latched address, start a new RD on the next edge.
REQ-024 A request withdrawn mid-access SHALL NOT truncate a strobe; the access completes and bus_busy falls as normal.
REQ-025 The wait counter SHALL be 4 bits and SHALL never wrap; bus_busy SHALL first assert the cycle after acceptance in IDLE.
REQ-026 mem_addr and mem_dq_o SHALL come only from the latched registers and stay constant for a whole access.

Reset
REQ-027 With reset_n=0 at an edge, the block SHALL enter IDLE and drive mem_ce_n=mem_oe_n=mem_we_n=1, mem_dq_oe=0, bus_busy=0, bus_rdata=0 and a zero wait counter. This applies mid-access; the aborted access is lost.

Configuration
REQ-028 Macro BUS_SRAM_WPOST_EN SHALL control posted writes.
REQ-029 When it is defined, a write in IDLE SHALL go to WR without asserting bus_busy, so the controller sees the write finish at once. Any new request accepted while WR/WR_REC is still draining SHALL see bus_busy=1 until the drain ends, then be served.
REQ-030 When it is undefined, writes SHALL behave as REQ-022.

Structure
REQ-031 A shared package bus_sram_pkg SHALL hold the state enum and the WAIT_CYCLES range-limit constants.
REQ-032 The wait-state counter SHALL be one sub-module, bus_wait_timer (load, count down, done pulse).
REQ-033 The FSM and datapath SHALL stay in bus_sram_slave.

Verification
REQ-034 Read hit: addr 0x0000_0010, WAIT_CYCLES=2, mem_dq_i=0xDEADBEEF -> ack the same cycle, busy high for 2 cycles, oe_n low for 2 cycles, bus_rdata=0xDEADBEEF, mem_addr=4.
REQ-035 Miss: addr 0x1000_0000 with rreq -> ack=0, no strobe, state stays IDLE.
REQ-036 Write: addr 0x8, wdata 0x12345678 -> we_n low for 2 cycles, then 1 recovery cycle, mem_dq_o=0x12345678 throughout, then busy low.
REQ-037 Withdrawal: rreq drops 1 cycle after acceptance -> oe_n still low for the full 2 cycles, then IDLE.
REQ-038 Reset mid-write: reset_n=0 during WR -> next edge gives all strobes high, dq_oe=0, busy=0.
REQ-039 With BUS_SRAM_WPOST_EN, a write then an immediate read -> no busy on the write; the read sees busy until the drain ends, then its data.

Source files
------------

// File: rtl/bus_sram_pkg.sv
// rtl/bus_sram_pkg.sv - shared FSM state type and wait-state limits for the SRAM bus slave
package bus_sram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        WR,
        WR_REC,
        DONE
    } state_t;

    localparam int WAIT_CNT_W = 4;
    localparam int WAIT_MIN   = 1;
    localparam int WAIT_MAX   = 15;

    // An out-of-range WAIT_CYCLES is pinned to the nearest legal strobe length.
    function automatic logic [WAIT_CNT_W-1:0] wait_load(input int cycles);
        if (cycles < WAIT_MIN) begin
            return WAIT_CNT_W'(WAIT_MIN);
        end else if (cycles > WAIT_MAX) begin
            return WAIT_CNT_W'(WAIT_MAX);
        end else begin
            return WAIT_CNT_W'(cycles);
        end
    endfunction

endpackage

// File: rtl/bus_wait_timer.sv
// rtl/bus_wait_timer.sv - loadable down-counter that flags the final cycle of an SRAM strobe
module bus_wait_timer
    import bus_sram_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [WAIT_CNT_W-1:0] load_val,
    output logic                  done
);

    logic [WAIT_CNT_W-1:0] cnt;

    // Parks at zero instead of wrapping, so done fires once per load.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == WAIT_CNT_W'(1)) && !load;

endmodule

// File: rtl/bus_sram_slave.sv
// rtl/bus_sram_slave.sv - bus-to-async-SRAM slave; define BUS_SRAM_WPOST_EN for posted writes
module bus_sram_slave
    import bus_sram_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter logic [31:0] ADDR_MASK   = 32'hFFC0_0000,
    parameter int          WAIT_CYCLES = 2,
    parameter int          MEM_AW      = 20
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       bus_addr,
    input  logic [31:0]       bus_wdata,
    input  logic              bus_rreq,
    input  logic              bus_wreq,
    output logic              bus_ack,
    output logic              bus_busy,
    output logic [31:0]       bus_rdata,
    output logic [MEM_AW-1:0] mem_addr,
    output logic [31:0]       mem_dq_o,
    output logic              mem_dq_oe,
    input  logic [31:0]       mem_dq_i,
    output logic              mem_ce_n,
    output logic              mem_oe_n,
    output logic              mem_we_n
);

`ifdef BUS_SRAM_WPOST_EN
    localparam bit WPOST = 1'b1;
`else
    localparam bit WPOST = 1'b0;
`endif

    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = wait_load(WAIT_CYCLES);

    state_t            state;
    logic              hit;
    logic [MEM_AW-1:0] req_word;
    logic [MEM_AW-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic              pend_valid;
    logic              pend_wr;
    logic [MEM_AW-1:0] pend_addr;
    logic [31:0]       pend_wdata;
    logic              start_en;
    logic              start_wr;
    logic [MEM_AW-1:0] start_addr;
    logic [31:0]       start_wdata;
    logic              t_done;

    assign hit      = ((bus_addr & ADDR_MASK) == (BASE_ADDR & ADDR_MASK));
    assign bus_ack  = (bus_rreq | bus_wreq) & hit;
    assign req_word = bus_addr[MEM_AW+1:2];
    assign mem_addr = lat_addr;
    assign mem_dq_o = lat_wdata;

    // One place decides which access starts next; the register block just launches it.
    always_comb begin
        start_en    = 1'b0;
        start_wr    = bus_wreq;
        start_addr  = req_word;
        start_wdata = bus_wdata;
        case (state)
            IDLE: start_en = bus_ack;
            DONE: begin
                start_en = bus_rreq & hit & (req_word != lat_addr);
                start_wr = 1'b0;
            end
            WR_REC: begin
                if (WPOST) begin
                    if (pend_valid) begin
                        start_en    = 1'b1;
                        start_wr    = pend_wr;
                        start_addr  = pend_addr;
                        start_wdata = pend_wdata;
                    end else begin
                        start_en = bus_ack;
                    end
                end
            end
            default: start_en = 1'b0;
        endcase
    end

    bus_wait_timer u_timer (
        .clk      (clk),
        .reset_n  (reset_n),
        .load     (start_en),
        .load_val (WAIT_LOAD),
        .done     (t_done)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            mem_ce_n   <= 1'b1;
            mem_oe_n   <= 1'b1;
            mem_we_n   <= 1'b1;
            mem_dq_oe  <= 1'b0;
            bus_busy   <= 1'b0;
            bus_rdata  <= '0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            pend_valid <= 1'b0;
            pend_wr    <= 1'b0;
            pend_addr  <= '0;
            pend_wdata <= '0;
        end else if (start_en) begin
            lat_addr   <= start_addr;
            mem_ce_n   <= 1'b0;
            pend_valid <= 1'b0;
            if (start_wr) begin
                state     <= WR;
                lat_wdata <= start_wdata;
                mem_we_n  <= 1'b0;
                mem_oe_n  <= 1'b1;
                mem_dq_oe <= 1'b1;
                bus_busy  <= ~WPOST;
            end else begin
                state     <= RD;
                mem_oe_n  <= 1'b0;
                mem_we_n  <= 1'b1;
                mem_dq_oe <= 1'b0;
                bus_busy  <= 1'b1;
            end
        end else begin
            case (state)
                RD: begin
                    if (t_done) begin
                        state     <= DONE;
                        bus_rdata <= mem_dq_i;
                        mem_ce_n  <= 1'b1;
                        mem_oe_n  <= 1'b1;
                        bus_busy  <= 1'b0;
                    end
                end
                WR: begin
                    if (t_done) begin
                        state    <= WR_REC;
                        mem_we_n <= 1'b1;
                    end
                    // A request arriving behind a posted write is parked until the drain ends.
                    if (WPOST && !pend_valid && bus_ack) begin
                        pend_valid <= 1'b1;
                        pend_wr    <= bus_wreq;
                        pend_addr  <= req_word;
                        pend_wdata <= bus_wdata;
                        bus_busy   <= 1'b1;
                    end
                end
                WR_REC: begin
                    state     <= WPOST ? IDLE : DONE;
                    mem_ce_n  <= 1'b1;
                    mem_dq_oe <= 1'b0;
                    bus_busy  <= 1'b0;
                end
                DONE: begin
                    if (!bus_rreq && !bus_wreq) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sram_slave.sv
// tb/tb_bus_sram_slave.sv - scoreboard bench for bus_sram_slave; BUS_SRAM_WPOST_EN adds the posted-write case
module tb_bus_sram_slave;

`ifdef BUS_SRAM_WPOST_EN
    localparam int WBUSY = 0;
`else
    localparam int WBUSY = 3;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] bus_addr = '0;
    logic [31:0] bus_wdata = '0;
    logic        bus_rreq = 1'b0;
    logic        bus_wreq = 1'b0;
    logic        bus_ack;
    logic        bus_busy;
    logic [31:0] bus_rdata;
    logic [19:0] mem_addr;
    logic [31:0] mem_dq_o;
    logic        mem_dq_oe;
    logic [31:0] mem_dq_i = '0;
    logic        mem_ce_n;
    logic        mem_oe_n;
    logic        mem_we_n;

    always #5 clk = ~clk;

    bus_sram_slave dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus_addr  (bus_addr),
        .bus_wdata (bus_wdata),
        .bus_rreq  (bus_rreq),
        .bus_wreq  (bus_wreq),
        .bus_ack   (bus_ack),
        .bus_busy  (bus_busy),
        .bus_rdata (bus_rdata),
        .mem_addr  (mem_addr),
        .mem_dq_o  (mem_dq_o),
        .mem_dq_oe (mem_dq_oe),
        .mem_dq_i  (mem_dq_i),
        .mem_ce_n  (mem_ce_n),
        .mem_oe_n  (mem_oe_n),
        .mem_we_n  (mem_we_n)
    );

    typedef struct {
        int          ce_low;
        int          we_low;
        int          rec;
        int          oe_low;
        int          busy;
        bit          has_w;
        bit          has_r;
        logic [19:0] waddr;
        logic [19:0] raddr;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    function automatic exp_t mk_rd(input logic [19:0] a, input logic [31:0] d);
        exp_t e;
        e = '{ce_low: 2, we_low: 0, rec: 0, oe_low: 2, busy: 2, has_w: 1'b0, has_r: 1'b1,
               waddr: '0, raddr: a, wdata: '0, rdata: d};
        return e;
    endfunction

    function automatic exp_t mk_wr(input logic [19:0] a, input logic [31:0] d);
        exp_t e;
        e = '{ce_low: 3, we_low: 2, rec: 1, oe_low: 0, busy: WBUSY, has_w: 1'b1, has_r: 1'b0,
               waddr: a, raddr: '0, wdata: d, rdata: '0};
        return e;
    endfunction

    // Monitor: measures each chip-enable window and settles it against the oldest expectation.
    int          m_ce, m_we, m_rec, m_oe, m_busy, m_bad;
    bit          m_in, m_wseen, m_rseen;
    logic [19:0] m_waddr, m_raddr;
    logic [31:0] m_wdata;
    exp_t        e;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_in = 1'b0;
        end else if (!mem_ce_n) begin
            if (!m_in) begin
                m_ce = 0; m_we = 0; m_rec = 0; m_oe = 0; m_busy = 0; m_bad = 0;
                m_wseen = 1'b0; m_rseen = 1'b0;
                m_in = 1'b1;
            end
            m_ce++;
            if (bus_busy) m_busy++;
            if (!mem_we_n) begin
                m_we++;
                if (!mem_dq_oe || !mem_oe_n) m_bad++;
                if (!m_wseen) begin
                    m_waddr = mem_addr; m_wdata = mem_dq_o; m_wseen = 1'b1;
                end else if (mem_addr !== m_waddr || mem_dq_o !== m_wdata) begin
                    m_bad++;
                end
            end else if (mem_oe_n) begin
                m_rec++;
                if (!mem_dq_oe || mem_dq_o !== m_wdata || mem_addr !== m_waddr) m_bad++;
            end else begin
                m_oe++;
                if (mem_dq_oe) m_bad++;
                if (!m_rseen) begin
                    m_raddr = mem_addr; m_rseen = 1'b1;
                end else if (mem_addr !== m_raddr) begin
                    m_bad++;
                end
            end
        end else if (m_in) begin
            m_in = 1'b0;
            if (exp_q.size() == 0) begin
                chk("unexpected_access", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ce_low_cycles", m_ce, e.ce_low);
                chk("we_low_cycles", m_we, e.we_low);
                chk("recovery_cycles", m_rec, e.rec);
                chk("oe_low_cycles", m_oe, e.oe_low);
                chk("busy_cycles", m_busy, e.busy);
                chk("busy_at_end", bus_busy, 0);
                chk("strobe_stability", m_bad, 0);
                if (e.has_w) begin
                    chk("write_addr", m_waddr, e.waddr);
                    chk("write_data", m_wdata, e.wdata);
                end
                if (e.has_r) begin
                    chk("read_addr", m_raddr, e.raddr);
                    chk("read_data", bus_rdata, e.rdata);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic issue(input bit rd, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input int hold, input bit exp_ack);
        bus_addr  = addr;
        bus_wdata = wdata;
        bus_rreq  = rd;
        bus_wreq  = wr;
        #1;
        chk("ack", bus_ack, exp_ack);
        repeat (hold) tick();
        bus_rreq = 1'b0;
        bus_wreq = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        idle(3);
        chk("reset_ce_n", mem_ce_n, 1);
        chk("reset_oe_n", mem_oe_n, 1);
        chk("reset_we_n", mem_we_n, 1);
        chk("reset_dq_oe", mem_dq_oe, 0);
        chk("reset_busy", bus_busy, 0);
        chk("reset_rdata", bus_rdata, 0);
        reset_n = 1'b1;
        tick();

        // Read hit at word 4.
        mem_dq_i = 32'hDEAD_BEEF;
        exp_q.push_back(mk_rd(20'h4, 32'hDEAD_BEEF));
        issue(1'b1, 1'b0, 32'h0000_0010, '0, 1, 1'b1);
        idle(6);

        // Misses, including the first address outside the 4 MiB window.
        issue(1'b1, 1'b0, 32'h1000_0000, '0, 1, 1'b0);
        issue(1'b0, 1'b1, 32'h0040_0000, 32'h1, 1, 1'b0);
        idle(2);
        chk("miss_no_strobe", mem_ce_n, 1);
        chk("miss_no_busy", bus_busy, 0);

        // Write with recovery cycle.
        exp_q.push_back(mk_wr(20'h2, 32'h1234_5678));
        issue(1'b0, 1'b1, 32'h0000_0008, 32'h1234_5678, 1, 1'b1);
        idle(6);

        // Read withdrawn one cycle after acceptance, at the top word of the window.
        mem_dq_i = 32'h5A5A_A5A5;
        exp_q.push_back(mk_rd(20'hF_FFFF, 32'h5A5A_A5A5));
        issue(1'b1, 1'b0, 32'h003F_FFFC, '0, 2, 1'b1);
        idle(6);

        // Simultaneous read and write: the write is taken.
        exp_q.push_back(mk_wr(20'h8, 32'hCAFE_F00D));
        issue(1'b1, 1'b1, 32'h0000_0020, 32'hCAFE_F00D, 1, 1'b1);
        idle(6);

        // Held read whose address moves while in DONE starts a second read.
        mem_dq_i = 32'h1111_2222;
        exp_q.push_back(mk_rd(20'h4, 32'h1111_2222));
        exp_q.push_back(mk_rd(20'h5, 32'h3333_4444));
        issue(1'b1, 1'b0, 32'h0000_0010, '0, 0, 1'b1);
        bus_rreq = 1'b1;
        idle(5);
        mem_dq_i = 32'h3333_4444;
        bus_addr = 32'h0000_0014;
        tick();
        bus_rreq = 1'b0;
        idle(6);

        // Reset during the write strobe aborts it.
        issue(1'b0, 1'b1, 32'h0000_0008, 32'h0F0F_0F0F, 1, 1'b1);
        reset_n = 1'b0;
        tick();
        chk("abort_ce_n", mem_ce_n, 1);
        chk("abort_oe_n", mem_oe_n, 1);
        chk("abort_we_n", mem_we_n, 1);
        chk("abort_dq_oe", mem_dq_oe, 0);
        chk("abort_busy", bus_busy, 0);
        chk("abort_rdata", bus_rdata, 0);
        reset_n = 1'b1;
        tick();

        mem_dq_i = 32'h7654_3210;
        exp_q.push_back(mk_rd(20'h4, 32'h7654_3210));
        issue(1'b1, 1'b0, 32'h0000_0010, '0, 1, 1'b1);
        idle(6);

`ifdef BUS_SRAM_WPOST_EN
        // Posted write followed at once by a read that waits out the drain.
        mem_dq_i = 32'h0BAD_F00D;
        exp_q.push_back('{ce_low: 5, we_low: 2, rec: 1, oe_low: 2, busy: 4, has_w: 1'b1, has_r: 1'b1,
                          waddr: 20'h2, raddr: 20'h10, wdata: 32'hA5A5_A5A5, rdata: 32'h0BAD_F00D});
        issue(1'b0, 1'b1, 32'h0000_0008, 32'hA5A5_A5A5, 1, 1'b1);
        issue(1'b1, 1'b0, 32'h0000_0040, '0, 1, 1'b1);
        idle(8);
`endif

        idle(4);
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
